serial_mag_comparator: RTL and testbench
========================================

Name: serial_mag_comparator

Overview:
- Parametrised, bit-serial, MSB-first magnitude comparator. It is the sequential successor to the team's fixed-width combinational 2-bit Eq/Gt/Lt comparator.
- Operands are captured on a start handshake and compared one bit per clock. The block then reports Eq/Gt/Lt with a one-cycle done pulse.
- Supports unsigned or two's-complement operands and optional early termination. It is used where a wide combinational comparator is too costly in gates.

Parameters:
WIDTH, 8, operand width in bits (legal range >= 2)
SIGNED, 0, 1 = operands are two's-complement; 0 = unsigned
EARLY_EXIT, 1, 1 = finish on the first differing bit; 0 = always scan all WIDTH bits (fixed latency)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request to begin; sampled only in IDLE
A  input  WIDTH  operand A; captured on the accepted start
B  input  WIDTH  operand B; captured on the accepted start
busy  output  1  high in CMP and DONE
done  output  1  single-cycle pulse when the result is valid
Eq  output  1  A == B
Gt  output  1  A > B
Lt  output  1  A < B

Behaviour:
- Reset: synchronous and active-high. While rst is high at a clock edge, the block goes to IDLE and forces busy=0, done=0, Eq=0, Gt=0, Lt=0. Shift registers and index are cleared.
- rst asserted mid-operation aborts the comparison. No done pulse is issued and the captured operands are discarded.
- States: IDLE, CMP, DONE. All outputs are registered.
- IDLE:
  - If start=1 at edge t, capture A and B into internal shift registers, set bit index to WIDTH-1, and clear Eq/Gt/Lt to 0.
  - Go to CMP and raise busy. With start=0, remain in IDLE and hold the outputs.
- CMP:
  - In cycle t+1+j (j = 0..WIDTH-1), examine bit WIDTH-1-j of the captured operands.
  - Unsigned, or any bit below the MSB: the first position where the bits differ decides the result. a=1, b=0 gives Gt; a=0, b=1 gives Lt.
  - SIGNED=1 and MSB: if the sign bits differ, a=1 (A negative) gives Lt and a=0 gives Gt. If the sign bits are equal, continue with the unsigned rule on the lower bits.
  - EARLY_EXIT=1: on the first differing bit, latch the verdict and go to DONE.
  - EARLY_EXIT=0: latch the first verdict in an internal "decided" flag. Later bits are ignored, and the scan continues to bit 0.
  - After bit 0 with no difference found, the result is Eq.
- DONE:
  - On entry, Eq/Gt/Lt are written; exactly one of them is 1.
  - done=1 for this single cycle only, then the block returns to IDLE with busy=0.
  - Eq/Gt/Lt hold their values until the next accepted start or reset.
- Latency, measured from the start edge t to the done cycle:
  - Full scan: done is high at cycle t+WIDTH+1.
  - EARLY_EXIT=1 with the first differing bit at index k: done is high at cycle t+WIDTH+1-k.
- Boundary rules:
  - start while busy (CMP or DONE) is ignored. Operands are not re-captured, and no queuing occurs.
  - A/B changes after capture have no effect on the comparison in progress.
  - The next start is accepted at the earliest in the cycle after DONE, i.e. when back in IDLE.
  - Simultaneous rst and start: reset wins.
  - Before the first completed operation, Eq=Gt=Lt=0, which means no valid result.

Test Plan:
- WIDTH=4, SIGNED=0, EARLY_EXIT=1; A=4'b1010, B=4'b0110, start at edge 0 -> done=1 in cycle 2, Gt=1, Eq=0, Lt=0; busy high in cycles 1-2.
- WIDTH=4, SIGNED=1; A=4'b1010 (-6), B=4'b0110 (+6) -> done in cycle 2, Lt=1; then A=4'b1110 (-2), B=4'b1010 (-6) -> Gt=1.
- WIDTH=4, EARLY_EXIT=1; A=B=4'b0101 -> done in cycle 5 (t+WIDTH+1), Eq=1; result holds in IDLE until the next start.
- WIDTH=4, EARLY_EXIT=0; A=4'b1000, B=4'b0111 -> done in cycle 5 (not 2), Gt=1; the later bits favouring B do not change the verdict.
- During CMP, pulse start with new A/B values -> ignored; the original result and latency are unchanged, and exactly one done pulse occurs.
- Assert rst in cycle 2 of a full scan -> from the next cycle busy=0 and Eq=Gt=Lt=0; no done pulse; a subsequent start completes normally.

Source files
------------

// File: rtl/serial_mag_comparator.sv
// Bit-serial, MSB-first magnitude comparator producing Eq/Gt/Lt with a one-cycle done pulse.
// Operands are latched on start and shifted out one bit per clock; optional early exit on the first difference.
module serial_mag_comparator #(
    parameter int WIDTH      = 8,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Eq,
    output logic             Gt,
    output logic             Lt
);

    localparam int            IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);
    localparam bit            SG      = (SIGNED != 0);
    localparam bit            EE      = (EARLY_EXIT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_decided;
    logic             r_dec_gt;
    logic             r_busy;
    logic             r_done;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;

    logic             w_bit_a;
    logic             w_bit_b;
    logic             w_diff;
    logic             w_msb;
    logic             w_a_wins;
    logic             w_last;
    logic             w_any_diff;
    logic             w_gt_final;
    logic             w_finish;

    // Per-bit verdict: on a signed sign bit, a set bit means the smaller operand.
    always_comb begin
        w_bit_a    = r_a[WIDTH-1];
        w_bit_b    = r_b[WIDTH-1];
        w_diff     = w_bit_a ^ w_bit_b;
        w_msb      = (r_idx == IDX_TOP);
        w_last     = (r_idx == {IW{1'b0}});
        w_a_wins   = (SG && w_msb) ? ~w_bit_a : w_bit_a;
        w_any_diff = r_decided | w_diff;
        w_gt_final = r_decided ? r_dec_gt : w_a_wins;
        w_finish   = w_last | (EE & w_diff);
    end

    // Control FSM, operand shift registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_a       <= {WIDTH{1'b0}};
            r_b       <= {WIDTH{1'b0}};
            r_idx     <= {IW{1'b0}};
            r_decided <= 1'b0;
            r_dec_gt  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_idx     <= IDX_TOP;
                        r_decided <= 1'b0;
                        r_dec_gt  <= 1'b0;
                        r_eq      <= 1'b0;
                        r_gt      <= 1'b0;
                        r_lt      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_CMP;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CMP: begin
                    // Only the first differing position may set the verdict in full-scan mode.
                    if (w_diff && !r_decided) begin
                        r_decided <= 1'b1;
                        r_dec_gt  <= w_a_wins;
                    end
                    if (w_finish) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_eq    <= ~w_any_diff;
                        r_gt    <= w_any_diff & w_gt_final;
                        r_lt    <= w_any_diff & ~w_gt_final;
                    end else begin
                        r_idx <= r_idx - IDX_ONE;
                        r_a   <= {r_a[WIDTH-2:0], 1'b0};
                        r_b   <= {r_b[WIDTH-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Eq   = r_eq;
    assign Gt   = r_gt;
    assign Lt   = r_lt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator: four configurations against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_mag_comparator;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [3:0]           start_s = 4'b0000;
    logic [3:0][7:0]      a_s = '0;
    logic [3:0][7:0]      b_s = '0;
    logic [3:0]           busy_s, done_s, eq_s, gt_s, lt_s;
    int                   n_vec = 0;
    int                   n_err = 0;

    always #5 clk = ~clk;

    // Instances: 0 = unsigned early-exit, 1 = signed early-exit, 2 = unsigned full scan, 3 = 8-bit signed full scan
    serial_mag_comparator #(.WIDTH(4), .SIGNED(0), .EARLY_EXIT(1)) u_uns (
        .clk(clk), .rst(rst), .start(start_s[0]), .A(a_s[0][3:0]), .B(b_s[0][3:0]),
        .busy(busy_s[0]), .done(done_s[0]), .Eq(eq_s[0]), .Gt(gt_s[0]), .Lt(lt_s[0]));
    serial_mag_comparator #(.WIDTH(4), .SIGNED(1), .EARLY_EXIT(1)) u_sgn (
        .clk(clk), .rst(rst), .start(start_s[1]), .A(a_s[1][3:0]), .B(b_s[1][3:0]),
        .busy(busy_s[1]), .done(done_s[1]), .Eq(eq_s[1]), .Gt(gt_s[1]), .Lt(lt_s[1]));
    serial_mag_comparator #(.WIDTH(4), .SIGNED(0), .EARLY_EXIT(0)) u_full (
        .clk(clk), .rst(rst), .start(start_s[2]), .A(a_s[2][3:0]), .B(b_s[2][3:0]),
        .busy(busy_s[2]), .done(done_s[2]), .Eq(eq_s[2]), .Gt(gt_s[2]), .Lt(lt_s[2]));
    serial_mag_comparator #(.WIDTH(8), .SIGNED(1), .EARLY_EXIT(0)) u_sfull (
        .clk(clk), .rst(rst), .start(start_s[3]), .A(a_s[3]), .B(b_s[3]),
        .busy(busy_s[3]), .done(done_s[3]), .Eq(eq_s[3]), .Gt(gt_s[3]), .Lt(lt_s[3]));

    function automatic int cfg_w(input int d);
        return (d == 3) ? 8 : 4;
    endfunction
    function automatic bit cfg_s(input int d);
        return (d == 1) || (d == 3);
    endfunction
    function automatic bit cfg_e(input int d);
        return (d == 0) || (d == 1);
    endfunction

    // Reference: numeric comparison of the operand values; latency from the highest differing bit.
    function automatic void ref_cmp(input int d, input logic [7:0] a, input logic [7:0] b,
                                    output logic [2:0] egl, output int lat);
        int w, va, vb, k;
        w  = cfg_w(d);
        va = int'(a) & ((1 << w) - 1);
        vb = int'(b) & ((1 << w) - 1);
        if (cfg_s(d) && va >= (1 << (w - 1))) va = va - (1 << w);
        if (cfg_s(d) && vb >= (1 << (w - 1))) vb = vb - (1 << w);
        egl = {va == vb, va > vb, va < vb};
        lat = w + 1;
        if (cfg_e(d) && va != vb) begin
            k = 0;
            for (int i = 0; i < w; i++) if (a[i] != b[i]) k = i;
            lat = w + 1 - k;
        end
    endfunction

    // Drives one operation and reports what was observed; the calling test judges it.
    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input bit poke,
                          output int done_cyc, output logic [2:0] egl, output bit busy_ok,
                          output bit clr_ok, output logic [1:0] post);
        bit seen;
        done_cyc = 0; egl = 3'b000; busy_ok = 1'b1; clr_ok = 1'b1; post = 2'b11;
        a_s[d] = a; b_s[d] = b; start_s[d] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            seen = done_s[d];
            if (busy_s[d] !== 1'b1) busy_ok = 1'b0;
            if (!seen && {eq_s[d], gt_s[d], lt_s[d]} !== 3'b000) clr_ok = 1'b0;
            start_s[d] = poke && (c == 1 || seen);
            if (poke) begin a_s[d] = 8'($urandom); b_s[d] = 8'($urandom); end
            if (seen) begin
                done_cyc = c;
                egl = {eq_s[d], gt_s[d], lt_s[d]};
                break;
            end
        end
        if (done_cyc != 0) begin
            @(negedge clk);
            post = {busy_s[d], done_s[d]};
        end
        start_s[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            n_vec++;
            if ({busy_s[d], done_s[d], eq_s[d], gt_s[d], lt_s[d]} !== 5'b00000) begin
                n_err++;
                $display("FAIL reset dut%0d: got busy/done/eq/gt/lt=%b expected 00000", d,
                         {busy_s[d], done_s[d], eq_s[d], gt_s[d], lt_s[d]});
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Directed vectors with hand-derived expectations: {dut, A, B, poke, latency, {Eq,Gt,Lt}}
    task automatic test_directed(input string name, input int d, input logic [7:0] a, input logic [7:0] b,
                                 input bit poke, input int exp_lat, input logic [2:0] exp_egl);
        int dc; logic [2:0] egl; bit bok, cok; logic [1:0] post;
        run_op(d, a, b, poke, dc, egl, bok, cok, post);
        n_vec++;
        if (dc !== exp_lat) begin n_err++; $display("FAIL %s latency: got %0d expected %0d", name, dc, exp_lat); end
        n_vec++;
        if (egl !== exp_egl) begin n_err++; $display("FAIL %s result EqGtLt: got %b expected %b", name, egl, exp_egl); end
        n_vec++;
        if (!bok || !cok) begin n_err++; $display("FAIL %s busy/clear during op: got busy_ok=%0d clr_ok=%0d expected 1 1", name, bok, cok); end
        n_vec++;
        if (post !== 2'b00) begin n_err++; $display("FAIL %s after done busy/done: got %b expected 00", name, post); end
    endtask

    task automatic test_unsigned();
        test_directed("uns_gt_msb", 0, 8'h0A, 8'h06, 1'b0, 2, 3'b010);
        test_directed("uns_lt_bit0", 0, 8'h04, 8'h05, 1'b0, 5, 3'b001);
    endtask

    task automatic test_signed();
        test_directed("sgn_neg_lt_pos", 1, 8'h0A, 8'h06, 1'b0, 2, 3'b001);
        test_directed("sgn_neg_neg_gt", 1, 8'h0E, 8'h0A, 1'b0, 3, 3'b010);
    endtask

    task automatic test_equal_hold();
        test_directed("eq_scan", 0, 8'h05, 8'h05, 1'b0, 5, 3'b100);
        repeat (4) @(negedge clk);
        n_vec++;
        if ({busy_s[0], done_s[0], eq_s[0], gt_s[0], lt_s[0]} !== 5'b00100) begin
            n_err++;
            $display("FAIL eq_hold: got busy/done/eq/gt/lt=%b expected 00100",
                     {busy_s[0], done_s[0], eq_s[0], gt_s[0], lt_s[0]});
        end
    endtask

    task automatic test_full_scan();
        test_directed("full_gt_first_bit", 2, 8'h08, 8'h07, 1'b0, 5, 3'b010);
        test_directed("full8_sign_lt", 3, 8'h80, 8'h7F, 1'b0, 9, 3'b001);
    endtask

    task automatic test_start_while_busy();
        test_directed("busy_start_uns", 0, 8'h0A, 8'h06, 1'b1, 2, 3'b010);
        test_directed("busy_start_full", 2, 8'h03, 8'h05, 1'b1, 5, 3'b001);
        test_directed("busy_start_sgn", 1, 8'h0E, 8'h0A, 1'b1, 3, 3'b010);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b; logic [2:0] exp_egl; int exp_lat;
        int dc; logic [2:0] egl; bit bok, cok; logic [1:0] post;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            ref_cmp(0, a, b, exp_egl, exp_lat);
            run_op(0, a, b, 1'b0, dc, egl, bok, cok, post);
            n_vec++;
            if (dc !== exp_lat || egl !== exp_egl || !bok || !cok || post !== 2'b00) begin
                n_err++;
                $display("FAIL b2b[%0d] A=%h B=%h: got lat=%0d egl=%b ok=%0d%0d post=%b expected lat=%0d egl=%b ok=11 post=00",
                         i, a[3:0], b[3:0], dc, egl, bok, cok, post, exp_lat, exp_egl);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b; logic [2:0] exp_egl; int exp_lat; int d; bit poke;
        int dc; logic [2:0] egl; bit bok, cok; logic [1:0] post;
        for (int i = 0; i < 48; i++) begin
            d = int'($urandom_range(3, 0));
            a = 8'($urandom); b = 8'($urandom);
            if ($urandom_range(3, 0) == 0) b = a;
            poke = 1'($urandom);
            ref_cmp(d, a, b, exp_egl, exp_lat);
            run_op(d, a, b, poke, dc, egl, bok, cok, post);
            n_vec++;
            if (dc !== exp_lat || egl !== exp_egl || !bok || !cok || post !== 2'b00) begin
                n_err++;
                $display("FAIL rand[%0d] dut%0d A=%h B=%h poke=%0d: got lat=%0d egl=%b ok=%0d%0d post=%b expected lat=%0d egl=%b ok=11 post=00",
                         i, d, a, b, poke, dc, egl, bok, cok, post, exp_lat, exp_egl);
            end
            if ($urandom_range(2, 0) == 0) @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        bit seen;
        a_s[2] = 8'h08; b_s[2] = 8'h07; start_s[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({busy_s[2], done_s[2], eq_s[2], gt_s[2], lt_s[2]} !== 5'b00000) begin
            n_err++;
            $display("FAIL abort_clear: got busy/done/eq/gt/lt=%b expected 00000",
                     {busy_s[2], done_s[2], eq_s[2], gt_s[2], lt_s[2]});
        end
        rst = 1'b0;
        seen = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (done_s[2] === 1'b1 || busy_s[2] === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL abort_no_done: got activity after abort=1 expected 0"); end
        test_directed("after_abort", 2, 8'h02, 8'h02, 1'b0, 5, 3'b100);
    endtask

    task automatic test_reset_vs_start();
        a_s[0] = 8'h0F; b_s[0] = 8'h01;
        rst = 1'b1; start_s[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0; start_s[0] = 1'b0;
        n_vec++;
        if ({busy_s[0], done_s[0], eq_s[0], gt_s[0], lt_s[0]} !== 5'b00000) begin
            n_err++;
            $display("FAIL rst_wins: got busy/done/eq/gt/lt=%b expected 00000",
                     {busy_s[0], done_s[0], eq_s[0], gt_s[0], lt_s[0]});
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy_s[0] !== 1'b0 || done_s[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_wins_idle: got busy=%b done=%b expected 0 0", busy_s[0], done_s[0]);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_equal_hold();
        test_full_scan();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_reset_vs_start();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
